// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder among NREQ requesters.
// One result slot; a new request may replace a result in the cycle it drains.
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_carry,
  output logic [2:0]            res_id,
  output logic [15:0]           op_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_carry_q;
  logic [2:0]       res_id_q;
  logic [2:0]       rr_ptr_q;
  logic [15:0]      op_count_q;

  logic             accept;
  logic             res_hs;
  logic             req_hs;
  logic [NREQ-1:0]  grant;
  logic [2:0]       gidx;
  logic             found;
  int               idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_d;
  logic [2:0]       rr_ptr_d;

  assign res_hs = ~reset & (state_q == BUSY) & res_ready;
  assign accept = ~reset & ((state_q == IDLE) | res_hs);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          gidx       = 3'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_hs    = found;
  assign req_ready = grant;

  assign op_a     = req_a[int'(gidx)*WIDTH +: WIDTH];
  assign op_b     = req_b[int'(gidx)*WIDTH +: WIDTH];
  assign sum_d    = {1'b0, op_a} + {1'b0, op_b};
  assign rr_ptr_d = 3'((int'(gidx) + 1) % NREQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
      op_count_q  <= '0;
    end else begin
      if (req_hs) begin
        state_q     <= BUSY;
        res_valid_q <= 1'b1;
        res_sum_q   <= sum_d[WIDTH-1:0];
        res_carry_q <= sum_d[WIDTH];
        res_id_q    <= gidx;
        rr_ptr_q    <= rr_ptr_d;
      end else if (res_hs) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
      end
      if (res_hs) begin
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: driver predicts grants and queues results,
// a negedge monitor pops and compares each result handshake.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [2:0]  res_id;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;

  logic [11:0] sb[$];
  logic [2:0]  m_ptr = '0;
  logic        m_busy = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic        mon_on = 1'b0;

  adder_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive after posedge, check grant, queue expected result
  task automatic cyc(input logic [3:0] rv, input logic [31:0] av,
                     input logic [31:0] bv, input logic rr,
                     input logic rst);
    logic [3:0] eg;
    logic [2:0] gi;
    logic       acc;
    logic [8:0] s;
    int         j;
    @(posedge clk);
    #1;
    req_valid = rv;
    req_a     = av;
    req_b     = bv;
    res_ready = rr;
    reset     = rst;
    #2;
    eg  = '0;
    gi  = '0;
    acc = !rst && (!m_busy || rr);
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        j = (int'(m_ptr) + k) % 4;
        if (eg == 4'b0 && rv[j]) begin
          eg[j] = 1'b1;
          gi    = 3'(j);
        end
      end
    end
    check("req_ready", {28'b0, req_ready}, {28'b0, eg});
    if (rst) begin
      sb.delete();
      m_ptr  = '0;
      m_busy = 1'b0;
    end else if (eg != 4'b0) begin
      s = {1'b0, av[int'(gi)*8 +: 8]} + {1'b0, bv[int'(gi)*8 +: 8]};
      sb.push_back({gi, s});
      m_ptr  = 3'((int'(gi) + 1) % 4);
      m_busy = 1'b1;
    end else if (m_busy && rr) begin
      m_busy = 1'b0;
    end
  endtask

  // Monitor: op_count tracking plus scoreboard pop on result handshake
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("op_count", {16'b0, op_count}, {16'b0, exp_cnt});
        if (reset) begin
          exp_cnt = '0;
        end else if (res_valid && res_ready) begin
          exp_cnt = exp_cnt + 16'd1;
          if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            check("res", {20'b0, res_id, res_carry, res_sum}, {20'b0, e});
          end
        end
      end
    end
  end

  logic [11:0] held;

  initial begin
    cyc(4'b0, '0, '0, 1'b0, 1'b1);
    cyc(4'b0, '0, '0, 1'b0, 1'b1);
    mon_on = 1'b1;
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("rst_state", {20'b0, res_valid, res_carry, res_id, res_sum, 1'b0},
          32'd0);
    check("rst_cnt", {16'b0, op_count}, 32'd0);

    // single request 5+3 from requester 0
    cyc(4'b0001, 32'hAAAA_AA05, 32'h5555_5503, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("single", {20'b0, res_valid, res_carry, res_id, res_sum},
          {20'b0, 1'b1, 1'b0, 3'd0, 8'h08});
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("single_cnt", {16'b0, op_count}, 32'd1);
    check("idle_valid", {31'b0, res_valid}, 32'd0);

    // overflow on requester 2, garbage in other slices
    cyc(4'b0100, 32'h12FF_3456, 32'hEE01_9A77, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("ovf", {20'b0, res_valid, res_carry, res_id, res_sum},
          {20'b0, 1'b1, 1'b1, 3'd2, 8'h00});

    // fairness from pointer 0
    cyc(4'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(4'b1111, 32'h4030_2010 + i, 32'h0403_0201, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("fair_cnt", {16'b0, op_count}, 32'd8);

    // backpressure: hold result three cycles
    cyc(4'b1111, 32'h0102_0304, 32'h1010_1010, 1'b1, 1'b0);
    cyc(4'b1111, 32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
    held = {res_id, res_carry, res_sum};
    check("bp_id", {29'b0, res_id}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(4'b1111, 32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
      check("bp_hold", {19'b0, res_valid, res_id, res_carry, res_sum},
            {19'b0, 1'b1, held});
    end
    cyc(4'b1111, 32'h0102_0304, 32'h1010_1010, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("bp_next", {20'b0, res_valid, res_carry, res_id, res_sum},
          {20'b0, 1'b1, 1'b0, 3'd1, 8'h13});
    cyc(4'b0, '0, '0, 1'b1, 1'b0);

    // reset while busy with requester 3
    cyc(4'b1000, 32'h0700_0000, 32'h0100_0000, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b0, 1'b0);
    check("busy3", {29'b0, res_id}, 32'd3);
    cyc(4'b0, '0, '0, 1'b0, 1'b1);
    cyc(4'b1010, 32'h0000_2200, 32'h0000_1100, 1'b1, 1'b0);
    check("mid_rst", {15'b0, res_valid, op_count}, 32'd0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("mid_rst_g", {20'b0, res_valid, res_carry, res_id, res_sum},
          {20'b0, 1'b1, 1'b0, 3'd1, 8'h33});
    cyc(4'b0, '0, '0, 1'b1, 1'b0);

    // op_count wrap
    cyc(4'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++)
      cyc(4'b1111, 32'(i), 32'(i * 3), 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("cnt_max", {16'b0, op_count}, 32'h0000_FFFF);
    cyc(4'b0001, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    cyc(4'b0, '0, '0, 1'b1, 1'b0);
    check("cnt_wrap", {16'b0, op_count}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand width of each requester and of the shared adder.
REQ-002 Parameter: NREQ, 4, number of requesters; legal range 2..8.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on posedge clk only.
REQ-005 Port: req_valid  input  NREQ  per-requester operation request.
REQ-006 Port: req_a  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 Port: req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
REQ-008 Port: req_ready  output  NREQ  one-hot-or-zero grant; a handshake on requester i is req_valid[i] & req_ready[i].
REQ-009 Port: res_valid  output  1  result available.
REQ-010 Port: res_ready  input  1  consumer accepts the result.
REQ-011 Port: res_sum  output  WIDTH  (a+b) modulo 2^WIDTH.
REQ-012 Port: res_carry  output  1  bit WIDTH of a+b.
REQ-013 Port: res_id  output  3  index of the requester that owns the result; unused upper bits are 0.
REQ-014 Port: op_count  output  16  count of completed result handshakes.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE (no result held) and BUSY (result held on the res_* outputs).
REQ-016 The accept condition SHALL be (state==IDLE) | (state==BUSY & res_ready), with reset deasserted.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr, state and res_ready; it SHALL never depend on req_a or req_b.
REQ-018 When accept is true and any req_valid bit is set, exactly one req_ready bit SHALL be asserted.
REQ-019 The asserted bit SHALL belong to the first valid requester found searching from rr_ptr upward, modulo NREQ.
REQ-020 When accept is false or no req_valid bit is set, req_ready SHALL be all zero.
REQ-021 On a handshake with requester g, the block SHALL register the result on the next posedge: res_sum=(a+b)[WIDTH-1:0], res_carry=(a+b)[WIDTH], res_id=g, res_valid=1, state=BUSY.
REQ-022 Latency SHALL be 1 cycle: res_valid is high in the cycle after the request handshake.
REQ-023 On a handshake with requester g, the block SHALL set rr_ptr to (g+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-024 In BUSY with res_ready=0, res_valid, res_sum, res_carry and res_id SHALL hold stable, and req_ready SHALL be 0.
REQ-025 On a result handshake (BUSY & res_ready) with a simultaneous request handshake, the new result SHALL replace the old one with no bubble, giving a throughput of 1 operation per cycle.
REQ-026 On a result handshake with no request handshake, the block SHALL go to IDLE with res_valid=0; res_sum, res_carry and res_id SHALL hold their last values.
REQ-027 op_count SHALL increment by 1 on every result handshake and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 A requester that deasserts req_valid without a handshake SHALL not change rr_ptr or any other state.
REQ-029 The carry SHALL be computed at WIDTH+1 bits; operand bits outside each requester's slice SHALL not influence that requester's result.

Reset
REQ-030 While reset=1 at a posedge, the block SHALL set: state=IDLE, res_valid=0, res_sum=0, res_carry=0, res_id=0, rr_ptr=0, op_count=0.
REQ-031 While reset=1, req_ready SHALL be all zero, and no handshake SHALL be counted.
REQ-032 Reset asserted in BUSY SHALL discard the held result; the first grant after reset SHALL search from requester 0.

Verification
REQ-033 Single request: req_valid=4'b0001, a0=8'h05, b0=8'h03, res_ready=1 -> req_ready=4'b0001 in cycle 0; in cycle 1 res_valid=1, res_sum=8'h08, res_carry=0, res_id=0, op_count=1 after that cycle.
REQ-034 Overflow: requester 2 with a=8'hFF, b=8'h01 -> res_sum=8'h00, res_carry=1, res_id=2.
REQ-035 Fairness: req_valid=4'b1111 held for 8 cycles with res_ready=1 -> grants in order 0,1,2,3,0,1,2,3, one per cycle, and op_count=8 after the last result drains.
REQ-036 Backpressure: res_ready=0 for 3 cycles while BUSY with req_valid=4'b1111 -> res_* stable, req_ready=0; on res_ready=1 the next requester in round-robin order is granted in that same cycle.
REQ-037 Reset mid-operation: reset=1 for one cycle while BUSY with res_id=3 -> next cycle res_valid=0, op_count=0; with req_valid=4'b1010 the next grant is requester 1.
REQ-038 Wrap: op_count forced to 16'hFFFF by driving 65535 results, plus one further result handshake -> op_count=16'h0000.
